// File: rtl/riscv_pkg.sv
// Shared types and constants for the end-of-test monitor.
//   mon_state_t        : monitor FSM states
//   halt_src_t         : what ended the test (encoding visible on halt_src)
//   FAIL_TIMEOUT       : fail_code reported when the cycle budget runs out
//   FAIL_MISMATCH_BASE : fail_code base for a check-channel mismatch (| index)
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } mon_state_t;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_TOHOST  = 2'd1,
    HALT_SPIN    = 2'd2,
    HALT_TIMEOUT = 2'd3
  } halt_src_t;

  localparam logic [31:0] FAIL_TIMEOUT       = 32'hFFFF_FFFF;
  localparam logic [31:0] FAIL_MISMATCH_BASE = 32'h0000_0100;

endpackage

// File: rtl/test_completion_monitor_spin_detector.sv
// Spin-loop detector: tracks an anchor fetch address and counts consecutive
// enabled fetches that land inside [anchor, anchor+STALL_WINDOW).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : re-arm pulse, zeroes anchor and counter
//   en         : qualified fetch strobe (only while the test is running)
//   addr       : fetch address
//   halt_hit   : this fetch brings the in-window count up to STALL_LIMIT
module spin_detector #(
  parameter int ALEN         = 32,
  parameter int STALL_WINDOW = 12,
  parameter int STALL_LIMIT  = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [ALEN-1:0] addr,
  output logic            halt_hit
);

  localparam int SC_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] LIM    = SC_W'(STALL_LIMIT);
  localparam logic [SC_W-1:0] LIM_M1 = SC_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);

  logic [ALEN-1:0] anchor;
  logic [SC_W-1:0] stall_cnt;
  logic            in_win;

  // Modular difference covers anchor+window wrapping past the top of memory.
  assign in_win   = (addr - anchor) < ALEN'(STALL_WINDOW);
  assign halt_hit = (STALL_LIMIT != 0) && en && in_win && (stall_cnt == LIM_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anchor    <= '0;
      stall_cnt <= '0;
    end else if (clr) begin
      anchor    <= '0;
      stall_cnt <= '0;
    end else if (en) begin
      if (in_win) begin
        // Saturate so a disabled limit never wraps the counter.
        if (stall_cnt != LIM) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        anchor    <= addr;
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/test_completion_monitor.sv
// End-of-test detector and result checker. Snoops fetch and store buses,
// ends the run on a tohost store, a fetch spin loop or a cycle timeout, then
// drains SETTLE_CYCLES and compares NUM_CHECKS tapped values.
//   start                 : arm pulse (honoured in IDLE or DONE)
//   imem_addr/imem_en     : instruction fetch bus
//   dmem_addr/wdata/we/be : data store bus
//   check_val/exp/mask    : per-channel observed, expected, enable
//   done/pass             : sticky result valid / passed
//   halt_src              : 0 none, 1 tohost, 2 spin, 3 timeout
//   fail_code             : tohost value, 0x100|channel, or all-ones on timeout
//   cycle_count           : RUN cycles elapsed (saturating)
module test_completion_monitor
  import riscv_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              ALEN           = 32,
  parameter logic [ALEN-1:0] TOHOST_ADDR    = 'h0000_1000,
  parameter int              TIMEOUT_CYCLES = 10000,
  parameter int              STALL_WINDOW   = 12,
  parameter int              STALL_LIMIT    = 256,
  parameter int              SETTLE_CYCLES  = 8,
  parameter int              NUM_CHECKS     = 4,
  localparam int             CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ALEN-1:0]            imem_addr,
  input  logic                       imem_en,
  input  logic [ALEN-1:0]            dmem_addr,
  input  logic [XLEN-1:0]            dmem_wdata,
  input  logic                       dmem_we,
  input  logic [3:0]                 dmem_be,
  input  logic [NUM_CHECKS*XLEN-1:0] check_val,
  input  logic [NUM_CHECKS*XLEN-1:0] check_exp,
  input  logic [NUM_CHECKS-1:0]      check_mask,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 halt_src,
  output logic [XLEN-1:0]            fail_code,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CI_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [ST_W-1:0]  ST_LAST   = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [CI_W-1:0]  CI_LAST   = CI_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TRIG  = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  mon_state_t      state;
  halt_src_t       halt_q;
  logic [XLEN-1:0] tohost_val;
  logic [ST_W-1:0] settle_cnt;
  logic [CI_W-1:0] chk_idx;
  logic            mm_seen;

  logic            arm;
  logic            fetch_en;
  logic            spin_hit;
  logic            tohost_hit;
  logic            timeout_hit;
  logic            ch_mm;
  logic            good_halt;
  logic [XLEN-1:0] mm_code;

  assign arm         = start && ((state == IDLE) || (state == DONE));
  assign fetch_en    = imem_en && (state == RUN);
  assign tohost_hit  = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_be == 4'hF);
  assign timeout_hit = (cycle_count == CNT_TRIG);
  assign ch_mm       = check_mask[chk_idx] &&
                       (check_val[int'(chk_idx)*XLEN +: XLEN] != check_exp[int'(chk_idx)*XLEN +: XLEN]);
  assign mm_code     = XLEN'(FAIL_MISMATCH_BASE) | XLEN'(chk_idx);
  assign good_halt   = (halt_q == HALT_SPIN) ||
                       ((halt_q == HALT_TOHOST) && (tohost_val == XLEN'(1)));
  assign halt_src    = halt_q;

  spin_detector #(
    .ALEN        (ALEN),
    .STALL_WINDOW(STALL_WINDOW),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_spin (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (arm),
    .en      (fetch_en),
    .addr    (imem_addr),
    .halt_hit(spin_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      halt_q      <= HALT_NONE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
      tohost_val  <= '0;
      settle_cnt  <= '0;
      chk_idx     <= '0;
      mm_seen     <= 1'b0;
    end else if (arm) begin
      state       <= RUN;
      halt_q      <= HALT_NONE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
      tohost_val  <= '0;
      mm_seen     <= 1'b0;
    end else begin
      unique case (state)
        // Run: watch for completion; tohost beats spin beats timeout.
        RUN: begin
          cycle_count <= sat_inc(cycle_count);
          if (tohost_hit) begin
            tohost_val <= dmem_wdata;
            halt_q     <= HALT_TOHOST;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (spin_hit) begin
            halt_q     <= HALT_SPIN;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (timeout_hit) begin
            halt_q    <= HALT_TIMEOUT;
            pass      <= 1'b0;
            fail_code <= XLEN'(FAIL_TIMEOUT);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        // Settle: let the pipeline drain before sampling results.
        SETTLE: begin
          if (settle_cnt == ST_LAST) begin
            chk_idx <= '0;
            state   <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        // Check: one channel per cycle; masked channels still take their slot.
        CHECK: begin
          if (ch_mm && !mm_seen) begin
            mm_seen   <= 1'b1;
            fail_code <= mm_code;
          end
          if (chk_idx == CI_LAST) begin
            done  <= 1'b1;
            pass  <= !(ch_mm || mm_seen) && good_halt;
            state <= DONE;
            // A bad tohost value outranks any channel mismatch code.
            if ((halt_q == HALT_TOHOST) && (tohost_val != XLEN'(1))) fail_code <= tohost_val;
          end else begin
            chk_idx <= chk_idx + 1'b1;
          end
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_completion_monitor.sv
module tb_test_completion_monitor;

  localparam int XLEN   = 32;
  localparam int NCH    = 4;
  localparam int TMO    = 10000;
  localparam int SETTLE = 8;
  localparam int WIN    = 12;
  localparam int CNT_W  = $clog2(TMO + 1);
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [31:0]         imem_addr = '0;
  logic                imem_en = 1'b0;
  logic [31:0]         dmem_addr = '0;
  logic [31:0]         dmem_wdata = '0;
  logic                dmem_we = 1'b0;
  logic [3:0]          dmem_be = '0;
  logic [NCH*XLEN-1:0] check_val = '0;
  logic [NCH*XLEN-1:0] check_exp = '0;
  logic [NCH-1:0]      check_mask = '0;

  logic             done_o [2];
  logic             pass_o [2];
  logic [1:0]       hs_o   [2];
  logic [31:0]      fc_o   [2];
  logic [CNT_W-1:0] cc_o   [2];

  // Instance 0: default spin limit. Instance 1: spin detection disabled.
  test_completion_monitor #(.STALL_LIMIT(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_en(imem_en),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .check_val(check_val), .check_exp(check_exp), .check_mask(check_mask),
    .done(done_o[0]), .pass(pass_o[0]), .halt_src(hs_o[0]),
    .fail_code(fc_o[0]), .cycle_count(cc_o[0])
  );

  test_completion_monitor #(.STALL_LIMIT(0)) u_dut_nospin (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_en(imem_en),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .check_val(check_val), .check_exp(check_exp), .check_mask(check_mask),
    .done(done_o[1]), .pass(pass_o[1]), .halt_src(hs_o[1]),
    .fail_code(fc_o[1]), .cycle_count(cc_o[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lim(input int m);
    return (m == 0) ? 256 : 0;
  endfunction

  task automatic check_zero(input string tag, input int m);
    check_eq($sformatf("%s/%0d done", tag, m), 32'(done_o[m]), 32'd0);
    check_eq($sformatf("%s/%0d pass", tag, m), 32'(pass_o[m]), 32'd0);
    check_eq($sformatf("%s/%0d halt", tag, m), 32'(hs_o[m]), 32'd0);
    check_eq($sformatf("%s/%0d fcode", tag, m), fc_o[m], 32'd0);
    check_eq($sformatf("%s/%0d ccount", tag, m), 32'(cc_o[m]), 32'd0);
  endtask

  // One armed run. The model replays the completion rules on the exact
  // stimulus driven each cycle and predicts trigger cycle, source and result.
  task automatic run_test(input string name, input int th_t, input logic [31:0] th_v,
                          input int part_t, input logic [31:0] spin_base, input int en_pct,
                          input logic [NCH*XLEN-1:0] cv, input logic [NCH*XLEN-1:0] ce,
                          input logic [NCH-1:0] cm, input bit start_in_chk, input int rst_at);
    int trig [2];
    int hsrc [2];
    int sc   [2];
    int dfirst [2];
    int dexp [2];
    logic [31:0] thv [2];
    logic [31:0] anc [2];
    int spin_k;
    int t;
    int fm;
    logic        ep;
    logic [31:0] ef;
    spin_k = 0;
    t = 0;
    for (int m = 0; m < 2; m++) begin
      trig[m] = -1; hsrc[m] = 0; sc[m] = 0; dfirst[m] = -1; dexp[m] = 0;
      thv[m] = '0; anc[m] = '0;
    end
    check_val = cv; check_exp = ce; check_mask = cm;
    @(negedge clk);
    start = 1'b1;
    while (1) begin
      @(negedge clk);
      t++;
      start = 1'b0;
      for (int m = 0; m < 2; m++)
        if (dfirst[m] < 0 && done_o[m]) dfirst[m] = t - 1;
      if (t == 1) begin
        check_eq({name, " restart done"}, 32'(done_o[0]), 32'd0);
        check_eq({name, " restart halt"}, 32'(hs_o[0]), 32'd0);
        check_eq({name, " restart fcode"}, fc_o[0], 32'd0);
        check_eq({name, " restart ccount"}, 32'(cc_o[0]), 32'd0);
        check_eq({name, " restart done/1"}, 32'(done_o[1]), 32'd0);
      end
      if (rst_at != 0 && t == rst_at) begin
        check_eq({name, " pre-reset halt"}, 32'(hs_o[0]), 32'(hsrc[0]));
        check_eq({name, " pre-reset ccount"}, 32'(cc_o[0]), 32'(trig[0]));
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) check_zero({name, " async"}, m);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (trig[0] >= 0 && trig[1] >= 0 && t > ((dexp[0] > dexp[1]) ? dexp[0] : dexp[1]) + 1)
        break;

      imem_en = ($urandom_range(0, 99) < en_pct);
      if (spin_base != 0) begin
        imem_addr = spin_base + 32'(4 * (spin_k % 3));
        if (imem_en) spin_k++;
      end else begin
        imem_addr = 32'h100 + 32'(4 * $urandom_range(0, 63));
      end
      dmem_wdata = $urandom;
      dmem_we    = 1'b0;
      dmem_be    = 4'hF;
      dmem_addr  = 32'h2000;
      case ($urandom_range(0, 7))
        0: begin dmem_we = 1'b1; dmem_addr = TOHOST; dmem_be = 4'($urandom_range(0, 14)); end
        1: begin dmem_we = 1'b1; dmem_addr = TOHOST + 32'd4; end
        default: ;
      endcase
      if (t == part_t) begin
        dmem_we = 1'b1; dmem_addr = TOHOST; dmem_be = 4'h3; dmem_wdata = 32'd1;
      end
      if (t == th_t) begin
        dmem_we = 1'b1; dmem_addr = TOHOST; dmem_be = 4'hF; dmem_wdata = th_v;
      end
      start = start_in_chk && trig[0] >= 0 && hsrc[0] != 3 && t == trig[0] + SETTLE + 2 &&
              (trig[1] < 0 || t <= dexp[1]);

      for (int m = 0; m < 2; m++) begin
        if (trig[m] < 0) begin
          if (dmem_we && dmem_addr == TOHOST && dmem_be == 4'hF) begin
            trig[m] = t; hsrc[m] = 1; thv[m] = dmem_wdata;
          end else begin
            if (imem_en) begin
              if (imem_addr - anc[m] < 32'(WIN)) begin
                sc[m]++;
                if (lim(m) != 0 && sc[m] == lim(m)) begin trig[m] = t; hsrc[m] = 2; end
              end else begin
                anc[m] = imem_addr; sc[m] = 0;
              end
            end
            if (trig[m] < 0 && t == TMO) begin trig[m] = t; hsrc[m] = 3; end
          end
          if (trig[m] >= 0) dexp[m] = (hsrc[m] == 3) ? trig[m] : trig[m] + SETTLE + NCH;
        end
      end
    end

    fm = -1;
    for (int i = 0; i < NCH; i++)
      if (fm < 0 && cm[i] && cv[i*XLEN +: XLEN] != ce[i*XLEN +: XLEN]) fm = i;
    for (int m = 0; m < 2; m++) begin
      if (hsrc[m] == 3) begin ep = 1'b0; ef = 32'hFFFF_FFFF; end
      else if (hsrc[m] == 1 && thv[m] != 32'd1) begin ep = 1'b0; ef = thv[m]; end
      else if (fm >= 0) begin ep = 1'b0; ef = 32'h100 | 32'(fm); end
      else begin ep = 1'b1; ef = 32'd0; end
      check_eq($sformatf("%s/%0d done_edge", name, m), 32'(dfirst[m]), 32'(dexp[m]));
      check_eq($sformatf("%s/%0d pass", name, m), 32'(pass_o[m]), 32'(ep));
      check_eq($sformatf("%s/%0d halt", name, m), 32'(hs_o[m]), 32'(hsrc[m]));
      check_eq($sformatf("%s/%0d fcode", name, m), fc_o[m], ef);
      check_eq($sformatf("%s/%0d ccount", name, m), 32'(cc_o[m]), 32'(trig[m]));
    end
  endtask

  initial begin
    logic [NCH*XLEN-1:0] v;
    logic [NCH*XLEN-1:0] v2;
    logic [NCH*XLEN-1:0] ce;
    logic [NCH*XLEN-1:0] cv;
    logic [NCH-1:0]      cm;
    logic [31:0]         tv;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) check_zero("reset", m);
    rst_n = 1'b1;

    for (int i = 0; i < NCH; i++) v[i*XLEN +: XLEN] = $urandom;
    v2 = v;
    v2[2*XLEN +: XLEN] = v[2*XLEN +: XLEN] ^ 32'h0000_0010;

    run_test("tohost_pass", 20, 32'd1, 0, 32'd0, 70, v, v, 4'hF, 1'b1, 0);
    run_test("tohost_bad", 30, 32'd7, 12, 32'd0, 70, v, v, 4'hF, 1'b0, 0);
    run_test("reset_settle", 5, 32'd1, 0, 32'd0, 70, v, v, 4'hF, 1'b0, 9);
    run_test("spin_mm", 0, 32'd0, 0, 32'h40, 80, v2, v, 4'hF, 1'b0, 0);
    run_test("spin_masked", 0, 32'd0, 0, 32'h40, 80, v2, v, 4'b1011, 1'b1, 0);
    run_test("timeout", 0, 32'd0, 0, 32'd0, 70, v, v, 4'hF, 1'b0, 0);
    run_test("timeout_tohost", TMO, 32'd1, 0, 32'd0, 70, v, v, 4'hF, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NCH; i++) begin
        ce[i*XLEN +: XLEN] = $urandom;
        cv[i*XLEN +: XLEN] = ($urandom_range(0, 3) == 0) ?
                             (ce[i*XLEN +: XLEN] ^ (32'd1 << $urandom_range(0, 31))) : ce[i*XLEN +: XLEN];
      end
      cm = 4'($urandom);
      tv = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'($urandom_range(0, 20));
      run_test($sformatf("rand%0d", r), $urandom_range(3, 300), tv, $urandom_range(0, 300),
               32'd0, $urandom_range(20, 100), cv, ce, cm, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
